// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared widths and limits for the serial sequence detector family
package fsm_pkg;

    // Widest match counter any detector instance may use.
    localparam int CNT_W_MAX = 32;

    // All-ones count limit at the widest width. Each instance keeps the low CNT_W bits.
    localparam logic [CNT_W_MAX-1:0] CNT_ALL_ONES = '1;

    // The state holds 0..n, so it needs $clog2(n+1) bits.
    function automatic int state_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// rtl/seq_prefix_match.sv - combinational next-state unit: longest pattern prefix matching the bit-stream suffix
//
// Ports:
//   hist    [N-1:0]  last N valid bits; bit 0 is the newest
//   b                incoming valid bit
//   k       [SW-1:0] current state, i.e. the number of prefix bits matched
//   pattern [N-1:0]  pattern; bit N-1 is expected first
//   overlap          1 = keep the matched suffix after a full match, 0 = restart
//   next_k  [SW-1:0] state after b is accepted
module seq_prefix_match
    import fsm_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = state_w(N)
) (
    input  logic [N-1:0]  hist,
    input  logic          b,
    input  logic [SW-1:0] k,
    input  logic [N-1:0]  pattern,
    input  logic          overlap,
    output logic [SW-1:0] next_k
);

    // The window is one bit wider than any candidate match. Its top bit
    // (the oldest history bit) never falls inside a mask, because a
    // candidate of length N uses only N-1 history bits plus b.
    logic [N:0] window;
    assign window = {hist, b};

    // Low j bits set: the positions a prefix of length j occupies in the window.
    function automatic logic [N:0] prefix_mask(input int j);
        logic [N:0] m;
        m = '0;
        for (int i = 0; i <= N; i++) begin
            if (i < j) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    int          kbase;
    logic [N:0]  aligned;

    always_comb begin
        next_k  = '0;
        aligned = '0;
        // In restart mode a completed match is forgotten before b is considered.
        kbase = (!overlap && (int'(k) == N)) ? 0 : int'(k);
        // Ascending loop, so the largest qualifying j is the one that sticks.
        for (int j = 1; j <= N; j++) begin
            // pattern[N-1 -: j] moves down to bits [j-1:0], with the first-expected bit lining up with the oldest bit.
            aligned = {1'b0, pattern} >> (N - j);
            if ((j <= kbase + 1) && (((window ^ aligned) & prefix_mask(j)) == '0)) begin
                next_k = SW'(j);
            end
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - parametrised Moore serial sequence detector with loadable pattern and saturating match counter
//
// Ports:
//   clk                       rising-edge clock
//   reset_n                   asynchronous active-low reset
//   in_valid, in              serial bit and its qualifier
//   cfg_load                  load cfg_pattern/cfg_overlap, restart detection, clear count
//   cfg_pattern [N-1:0]       new pattern; bit N-1 is expected first
//   cfg_overlap               1 = overlapping matches, 0 = restart after a match
//   out                       high while the state is N (full match)
//   state_o     [SW-1:0]      number of pattern bits currently matched
//   match_count [CNT_W-1:0]   saturating match count
//   count_sat                 match_count is all ones
module moore_seq_detector
    import fsm_pkg::*;
#(
    parameter int           N             = 4,
    parameter logic [N-1:0] RESET_PATTERN = 4'b1011,
    parameter logic         RESET_OVERLAP = 1'b1,
    parameter int           CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic                   in,
    input  logic                   cfg_load,
    input  logic [N-1:0]           cfg_pattern,
    input  logic                   cfg_overlap,
    output logic                   out,
    output logic [state_w(N)-1:0]  state_o,
    output logic [CNT_W-1:0]       match_count,
    output logic                   count_sat
);

    localparam int               SW        = state_w(N);
    localparam logic [SW-1:0]    FULL      = SW'(N);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_ALL_ONES[CNT_W-1:0];

    logic [SW-1:0]    state_q, state_d, match_k;
    logic [N-1:0]     hist_q, hist_d;
    logic [N-1:0]     pattern_q;
    logic             overlap_q;
    logic [CNT_W-1:0] cnt_q;

    seq_prefix_match #(
        .N  (N),
        .SW (SW)
    ) u_match (
        .hist    (hist_q),
        .b       (in),
        .k       (state_q),
        .pattern (pattern_q),
        .overlap (overlap_q),
        .next_k  (match_k)
    );

    // State register (with the history that qualifies it).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
        end
    end

    // Next state: reconfiguration wins over a bit arriving on the same edge.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        if (cfg_load) begin
            state_d = '0;
            hist_d  = '0;
        end else if (in_valid) begin
            state_d = match_k;
            hist_d  = {hist_q[N-2:0], in};
        end
    end

    // Outputs come from registers only; nothing from in reaches out combinationally.
    always_comb begin
        out         = (state_q == FULL);
        state_o     = state_q;
        match_count = cnt_q;
        count_sat   = (cnt_q == CNT_LIMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= RESET_PATTERN;
            overlap_q <= RESET_OVERLAP;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            overlap_q <= cfg_overlap;
        end
    end

    // Counts on the same edge the state reaches N, so count and out change together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cfg_load) begin
            cnt_q <= '0;
        end else if (in_valid && (match_k == FULL) && (cnt_q != CNT_LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
